// File: rtl/counter_cmd_ctrl.sv
// Command sequencer for the up/down loadable counter: accepts one NOP/LOAD/COUNT
// command at a time and drives the counter control pins, flagging wrap-around.
module counter_cmd_ctrl #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STEP_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [WIDTH-1:0]  cmd_data_i,
    input  logic [STEP_W-1:0] cmd_steps_i,
    output logic              ce_o,
    output logic              up_down_o,
    output logic              load_n_o,
    output logic [WIDTH-1:0]  data_load_o,
    input  logic [WIDTH-1:0]  count_out_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              wrapped_o
);

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_e;

    state_e              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                ce_q, ce_d;
    logic                up_down_q, up_down_d;
    logic                load_n_q, load_n_d;
    logic [WIDTH-1:0]    data_load_q, data_load_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                wrapped_q, wrapped_d;
    logic [STEP_W-1:0]   steps_q, steps_d;
    logic                wrap_hit;

    // Terminal value for the current direction, seen while the counter is enabled
    assign wrap_hit = ce_q && ((up_down_q && (count_out_i == {WIDTH{1'b1}})) ||
                               (!up_down_q && (count_out_i == {WIDTH{1'b0}})));

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        ce_d        = 1'b0;
        up_down_d   = up_down_q;
        load_n_d    = 1'b1;
        data_load_d = data_load_q;
        done_d      = 1'b0;
        wrapped_d   = wrapped_q;
        steps_d     = steps_q;

        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid_i && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    wrapped_d   = 1'b0;
                    if (cmd_op_i == OP_NOP) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (cmd_op_i == OP_LOAD) begin
                        state_d     = S_LOAD;
                        load_n_d    = 1'b0;
                        data_load_d = cmd_data_i;
                    end else begin
                        up_down_d = ~cmd_op_i[0];
                        if (cmd_steps_i != '0) begin
                            state_d = S_RUN;
                            ce_d    = 1'b1;
                            steps_d = cmd_steps_i;
                        end else begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            S_LOAD: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            S_RUN: begin
                if (wrap_hit) begin
                    wrapped_d = 1'b1;
                end
                // steps_q counts the enable cycles still owed, including the current one
                if (steps_q <= STEP_W'(1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    steps_d = '0;
                end else begin
                    ce_d    = 1'b1;
                    steps_d = steps_q - STEP_W'(1);
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                cmd_ready_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            ce_q        <= 1'b0;
            up_down_q   <= 1'b1;
            load_n_q    <= 1'b1;
            data_load_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wrapped_q   <= 1'b0;
            steps_q     <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            ce_q        <= ce_d;
            up_down_q   <= up_down_d;
            load_n_q    <= load_n_d;
            data_load_q <= data_load_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wrapped_q   <= wrapped_d;
            steps_q     <= steps_d;
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign ce_o        = ce_q;
    assign up_down_o   = up_down_q;
    assign load_n_o    = load_n_q;
    assign data_load_o = data_load_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign wrapped_o   = wrapped_q;

endmodule
